// File: rtl/pcie_mwr_tlp_gen.sv
// Memory Write TLP generator for one PCIe TX arbiter input port.
// Takes a DMA write command, pulls the payload from an FWFT FIFO and emits a
// single 3DW-header MWr TLP on a 64-bit AXI-Stream (7-series core format).
module pcie_mwr_tlp_gen #(
  parameter int unsigned C_DATA_WIDTH   = 64,
  parameter int unsigned KEEP_WIDTH     = C_DATA_WIDTH / 8,
  parameter int unsigned MAX_PAYLOAD_DW = 32
) (
  input  logic                    clk,
  input  logic                    sys_rst_n,
  input  logic [15:0]             requester_id,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [31:0]             cmd_addr,
  input  logic [9:0]              cmd_len,
  output logic                    cmd_err,
  input  logic [C_DATA_WIDTH-1:0] data_in,
  input  logic                    data_empty,
  output logic                    data_rd,
  output logic                    tx_req,
  input  logic                    tx_ack,
  input  logic                    s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
  output logic                    s_axis_tx_tlast,
  output logic                    s_axis_tx_tvalid,
  output logic                    tx_src_dsc,
  output logic                    tlp_done,
  output logic [31:0]             tlp_count
);

  typedef enum logic [2:0] {StIdle, StReq, StHdr, StD1, StData, StRel} state_e;

  localparam logic [10:0] MaxLen = 11'(MAX_PAYLOAD_DW);

  state_e      state_q, state_d;
  logic [29:0] addr_q;
  logic [9:0]  len_q;
  logic [9:0]  last_idx_q;   // index of the final beat (beats - 1)
  logic [9:0]  words_q;      // FIFO words to pop for this TLP
  logic        half_last_q;  // final beat carries only one DW
  logic [9:0]  beat_q;
  logic [31:0] hold_q;       // upper DW of the last popped FIFO word
  logic        cmd_err_q;
  logic [31:0] tlp_count_q;

  logic [10:0] len_ext;
  logic        len_ok;
  logic        cmd_fire;
  logic        is_last;
  logic        word_used;
  logic        beat_acc;
  logic [3:0]  last_be;
  logic [31:0] hdr_dw0;
  logic [31:0] hdr_dw1;
  logic        unused_addr_bits;

  // Byte address is DW aligned in the header; low bits carry no information.
  assign unused_addr_bits = ^cmd_addr[1:0];

  assign len_ext  = {1'b0, cmd_len};
  assign len_ok   = (cmd_len != 10'd0) && (len_ext <= MaxLen);
  assign cmd_fire = cmd_valid && cmd_ready;
  assign is_last  = (beat_q == last_idx_q);
  assign last_be  = (len_q > 10'd1) ? 4'hF : 4'h0;
  assign hdr_dw0  = {3'b010, 19'd0, len_q};
  assign hdr_dw1  = {requester_id, 8'h00, last_be, 4'hF};

  assign cmd_err    = cmd_err_q;
  assign tlp_count  = tlp_count_q;
  assign tx_src_dsc = 1'b0;

  // Next-state and AXI-Stream/arbiter outputs, all decoded from the current state.
  always_comb begin
    state_d          = state_q;
    cmd_ready        = 1'b0;
    tx_req           = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    word_used        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gate with reset so every output reads 0 while reset is held.
        cmd_ready = sys_rst_n;
        if (cmd_valid && sys_rst_n && len_ok) state_d = StReq;
      end
      StReq: begin
        tx_req = 1'b1;
        if (tx_ack) state_d = StHdr;
      end
      StHdr: begin
        tx_req           = 1'b1;
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tdata  = {hdr_dw1, hdr_dw0};
        s_axis_tx_tkeep  = 8'hFF;
        if (s_axis_tx_tready) state_d = StD1;
      end
      StD1: begin
        tx_req           = 1'b1;
        word_used        = 1'b1;
        s_axis_tx_tvalid = ~data_empty;
        s_axis_tx_tdata  = {data_in[31:0], addr_q, 2'b00};
        s_axis_tx_tlast  = is_last;
        s_axis_tx_tkeep  = (is_last && half_last_q) ? 8'h0F : 8'hFF;
      end
      StData: begin
        tx_req           = 1'b1;
        // Beat n needs FIFO word n-1 only while n-1 < words.
        word_used        = (beat_q <= words_q);
        s_axis_tx_tvalid = word_used ? ~data_empty : 1'b1;
        s_axis_tx_tdata  = {(word_used ? data_in[31:0] : 32'h0), hold_q};
        s_axis_tx_tlast  = is_last;
        s_axis_tx_tkeep  = (is_last && half_last_q) ? 8'h0F : 8'hFF;
      end
      StRel: begin
        if (!tx_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    beat_acc = s_axis_tx_tvalid && s_axis_tx_tready;
    if (beat_acc && (state_q == StD1 || state_q == StData)) begin
      state_d = is_last ? StRel : StData;
    end
    data_rd  = beat_acc && word_used;
    tlp_done = beat_acc && s_axis_tx_tlast;
  end

  // State register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // Command latch: address, length and derived beat/word counts.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q      <= '0;
      len_q       <= '0;
      last_idx_q  <= '0;
      words_q     <= '0;
      half_last_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_err_q <= cmd_fire && !len_ok;
      if (cmd_fire && len_ok) begin
        addr_q      <= cmd_addr[31:2];
        len_q       <= cmd_len;
        last_idx_q  <= 10'((len_ext + 11'd2) >> 1);
        words_q     <= 10'((len_ext + 11'd1) >> 1);
        half_last_q <= ~cmd_len[0];
      end
    end
  end

  // Beat counter and upper-DW holding register for the DW shift.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beat_q <= '0;
      hold_q <= '0;
    end else begin
      if (cmd_fire) beat_q <= '0;
      else if (beat_acc) beat_q <= beat_q + 10'd1;
      if (data_rd) hold_q <= data_in[63:32];
    end
  end

  // Completed TLP counter, wraps naturally.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    tlp_count_q <= '0;
    else if (tlp_done) tlp_count_q <= tlp_count_q + 32'd1;
  end

endmodule

// File: doc/pcie_mwr_tlp_gen.md
Name: pcie_mwr_tlp_gen

Overview:
- Upstream requester stage for one input port of the PCIe TX arbiter/mux.
- Accepts a DMA write command (address, length), fetches payload from a first-word-fall-through (FWFT) data FIFO, and emits one 3DW-header Memory Write TLP.
- The TLP is driven on a 64-bit AXI-Stream interface in 7-series PCIe core format.
- Owns the arbiter handshake: holds req high for the whole TLP and releases it after tlast.

Parameters:
- C_DATA_WIDTH, 64, AXIS data width; only 64 is supported.
- KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width.
- MAX_PAYLOAD_DW, 32, maximum accepted payload length in DWs (1..1023).

Ports:
- clk  in  1  core user clock
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- requester_id  in  16  completer/requester ID placed in header DW1
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_addr  in  32  byte address; bits [1:0] ignored
- cmd_len  in  10  payload length in DWs
- cmd_err  out  1  one-cycle pulse: command dropped for bad length
- data_in  in  64  FIFO head word; even DW in [31:0], odd DW in [63:32]
- data_empty  in  1  FIFO empty
- data_rd  out  1  pop FIFO head
- tx_req  out  1  request to arbiter
- tx_ack  in  1  grant from arbiter
- s_axis_tx_tready  in  1  downstream ready (already gated by grant)
- s_axis_tx_tdata  out  64  TLP data
- s_axis_tx_tkeep  out  8  byte enables
- s_axis_tx_tlast  out  1  last beat
- s_axis_tx_tvalid  out  1  beat valid
- tx_src_dsc  out  1  discontinue; constant 0
- tlp_done  out  1  one-cycle pulse on accepted tlast beat
- tlp_count  out  32  wrapping count of completed TLPs

Behaviour:
- Reset (sys_rst_n low, asynchronous): all outputs 0, state IDLE, tlp_count=0, holding register=0. Reset mid-TLP aborts immediately: tvalid and tx_req fall, no data_rd.
- States: IDLE, REQ, HDR, D1, DATA, REL.
- IDLE: cmd_ready=1.
  - On cmd_valid with cmd_len==0 or cmd_len>MAX_PAYLOAD_DW: pulse cmd_err next cycle; stay IDLE.
  - Otherwise latch addr and len, compute beats = ceil((3+len)/2) and words = ceil(len/2), go to REQ.
- REQ: tx_req=1; wait for tx_ack=1, then go to HDR. tx_req stays 1 until REL.
- HDR: beat0, tvalid=1, tdata = {DW1, DW0}, tkeep=FF.
  - DW0 = fmt 3'b010, type 0, TC/TD/EP/attr 0, length=len.
  - DW1 = {requester_id, tag 8'h00, lastBE, firstBE 4'hF}; lastBE=4'hF if len>1, else 4'h0.
  - Advance on tready.
- D1: beat1, tdata = {data_in[31:0], addr[31:2],2'b00}; tvalid = ~data_empty.
  - On acceptance: data_rd=1, hold data_in[63:32].
- DATA: beat n≥2, tdata = {word[n-1][31:0], hold}.
  - If word n-1 exists (n-1 < words): tvalid = ~data_empty, data_rd on acceptance, hold updates.
  - Otherwise (final beat, odd DW total) tvalid=1 with no FIFO dependency, upper DW = 0.
- Last beat (n = beats-1):
  - tlast=1.
  - tkeep = 8'h0F if (3+len) is odd, else 8'hFF; all other beats FF.
  - On acceptance: tlp_done pulse, tlp_count+1 (wraps at 2^32), go to REL.
- REL: tx_req=0, tvalid=0; return to IDLE once tx_ack=0.
- data_rd asserts only when tvalid&tready&(word consumed); never when data_empty. Exactly `words` pops per TLP.
- FIFO underrun mid-TLP: tvalid=0 and beat held (stall, no bubble corruption); tx_req stays high.
- tready low: tdata/tkeep/tlast stable while tvalid=1.
- cmd_ready=0 outside IDLE; commands presented then are held off, never lost.
- tx_ack dropping during HDR/D1/DATA (illegal arbiter behaviour): output frozen; no recovery required.

Test Plan:
- len=1, addr=0x1000_0004, data word 0x0000_0000_AABB_CCDD, reqid=0x0100 -> 2 beats: {0x0100_000F, 0x4000_0001} then {0xAABB_CCDD, 0x1000_0004} tkeep FF tlast; 1 data_rd; tlp_done; tlp_count=1.
- len=2, words 0x2222_2222_1111_1111 -> 3 beats; beat1 low=addr, high=0x1111_1111; beat2 = {x, 0x2222_2222}, tkeep 0F, tlast; 1 data_rd; DW1 lastBE=F.
- len=8 with data_empty toggled high for 3 cycles mid-TLP and random tready -> tvalid drops during empty, no duplicated/missing DW, 6 beats, tlast on 6th, 4 pops, tkeep 0F.
- cmd_len=0 and cmd_len=33 -> cmd_err pulse each, no tx_req, no data_rd, tlp_count unchanged.
- tx_ack delayed 5 cycles, then back-to-back commands -> tvalid=0 until ack; tx_req drops after each tlast, second TLP starts only after ack returns to 0 then 1.
- sys_rst_n pulsed low during DATA beat 3 -> all outputs 0 asynchronously; after release, next command produces a clean full TLP.
